// File: rtl/alu_pkg.sv
// Shared op codes, FSM state type and width helper for the accumulator ALU.
package alu_pkg;

    localparam logic [2:0] OP_INC = 3'b000;
    localparam logic [2:0] OP_ADD = 3'b001;
    localparam logic [2:0] OP_SUB = 3'b010;
    localparam logic [2:0] OP_XOR = 3'b011;
    localparam logic [2:0] OP_ROR = 3'b100;
    localparam logic [2:0] OP_SHL = 3'b101;
    localparam logic [2:0] OP_SHR = 3'b110;
    localparam logic [2:0] OP_MUL = 3'b111;

    typedef enum logic {
        IDLE = 1'b0,
        MUL  = 1'b1
    } state_t;

    // Full product width: a WIDTH-bit multiplicand times an A_WIDTH-bit multiplier.
    function automatic int prod_width(input int width, input int a_width);
        return width + a_width;
    endfunction

endpackage

// File: rtl/alu_accumulator_if.sv
// Operand/op/handshake bundle between the switch logic and the accumulator ALU.
interface alu_accumulator_if #(
    parameter int WIDTH   = 8,
    parameter int A_WIDTH = 4
);
    logic [A_WIDTH-1:0] a;
    logic [2:0]         op;
    logic               start;
    logic               clear;
    logic [WIDTH-1:0]   acc;
    logic               carry;
    logic               zero;
    logic               busy;
    logic               done;

    modport master (
        output a, op, start, clear,
        input  acc, carry, zero, busy, done
    );

    modport slave (
        input  a, op, start, clear,
        output acc, carry, zero, busy, done
    );
endinterface

// File: rtl/shift_add_multiplier.sv
// Sequential shift-add multiplier: one multiplier bit per clock, LSB first.
module shift_add_multiplier
    import alu_pkg::*;
#(
    parameter int WIDTH   = 8,
    parameter int A_WIDTH = 4
) (
    input  logic                                   clock,
    input  logic                                   reset,
    input  logic                                   abort,
    input  logic                                   load,
    input  logic [A_WIDTH-1:0]                     mplier_in,
    input  logic [WIDTH-1:0]                       mcand_in,
    output logic                                   finish,
    output logic [prod_width(WIDTH, A_WIDTH)-1:0]  product
);
    localparam int P  = prod_width(WIDTH, A_WIDTH);
    localparam int CW = $clog2(A_WIDTH + 1);
    localparam logic [CW-1:0] LAST = CW'(A_WIDTH - 1);

    logic [A_WIDTH-1:0] mplier_q, mplier_d;
    logic [P-1:0]       mcand_q, mcand_d;
    logic [P-1:0]       partial_q, partial_d;
    logic [CW-1:0]      count_q, count_d;
    logic               active_q, active_d;

    // Load operands, or fold in one shifted multiplicand per cycle while active.
    always_comb begin
        mplier_d  = mplier_q;
        mcand_d   = mcand_q;
        partial_d = partial_q;
        count_d   = count_q;
        active_d  = active_q;
        finish    = 1'b0;
        product   = partial_q + (mplier_q[0] ? mcand_q : '0);
        if (abort) begin
            active_d = 1'b0;
        end else if (load) begin
            mplier_d  = mplier_in;
            mcand_d   = P'(mcand_in);
            partial_d = '0;
            count_d   = '0;
            active_d  = 1'b1;
        end else if (active_q) begin
            partial_d = product;
            mplier_d  = mplier_q >> 1;
            mcand_d   = mcand_q << 1;
            count_d   = count_q + CW'(1);
            if (count_q == LAST) begin
                // product already includes the last bit, so the caller takes it this edge
                finish   = 1'b1;
                active_d = 1'b0;
            end
        end
    end

    // Multiplier state registers.
    always_ff @(posedge clock) begin
        if (reset) begin
            mplier_q  <= '0;
            mcand_q   <= '0;
            partial_q <= '0;
            count_q   <= '0;
            active_q  <= 1'b0;
        end else begin
            mplier_q  <= mplier_d;
            mcand_q   <= mcand_d;
            partial_q <= partial_d;
            count_q   <= count_d;
            active_q  <= active_d;
        end
    end

endmodule

// File: rtl/alu_accumulator.sv
// Accumulator ALU: single-cycle ops write back immediately, multiply runs multi-cycle.
module alu_accumulator
    import alu_pkg::*;
#(
    parameter int WIDTH   = 8,
    parameter int A_WIDTH = 4
) (
    input  logic        clock,
    input  logic        reset,
    alu_accumulator_if.slave bus
);
    localparam int P = prod_width(WIDTH, A_WIDTH);
    localparam int unsigned WU = WIDTH;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] acc_q, acc_d;
    logic             carry_q, carry_d;
    logic             done_q, done_d;

    logic             single_go;
    logic             mul_load;
    logic             mul_finish;
    logic [P-1:0]     product;
    logic [WIDTH-1:0] a_ext;
    logic [WIDTH:0]   wide;
    logic [WIDTH-1:0] alu_res;
    logic             alu_carry;

    assign a_ext = WIDTH'(bus.a);

    shift_add_multiplier #(
        .WIDTH   (WIDTH),
        .A_WIDTH (A_WIDTH)
    ) u_mul (
        .clock     (clock),
        .reset     (reset),
        .abort     (bus.clear),
        .load      (mul_load),
        .mplier_in (bus.a),
        .mcand_in  (acc_q),
        .finish    (mul_finish),
        .product   (product)
    );

    // FSM state register.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next state: enter MUL on an accepted multiply, leave on finish or clear.
    always_comb begin
        state_d = state_q;
        if (bus.clear) begin
            state_d = IDLE;
        end else begin
            case (state_q)
                IDLE:    if (bus.start && bus.op == OP_MUL) state_d = MUL;
                MUL:     if (mul_finish) state_d = IDLE;
                default: state_d = IDLE;
            endcase
        end
    end

    // FSM outputs: accept strobes and busy.
    always_comb begin
        single_go = (state_q == IDLE) && bus.start && (bus.op != OP_MUL) && !bus.clear;
        mul_load  = (state_q == IDLE) && bus.start && (bus.op == OP_MUL) && !bus.clear;
        bus.busy  = (state_q == MUL);
    end

    // Single-cycle op results; shifts by A >= WIDTH give zero.
    always_comb begin
        wide      = '0;
        alu_res   = acc_q;
        alu_carry = 1'b0;
        case (bus.op)
            OP_INC: begin
                wide      = {1'b0, a_ext} + (WIDTH+1)'(1);
                alu_res   = wide[WIDTH-1:0];
                alu_carry = wide[WIDTH];
            end
            OP_ADD: begin
                wide      = {1'b0, a_ext} + {1'b0, acc_q};
                alu_res   = wide[WIDTH-1:0];
                alu_carry = wide[WIDTH];
            end
            OP_SUB: begin
                wide      = {1'b0, acc_q} - {1'b0, a_ext};
                alu_res   = wide[WIDTH-1:0];
                alu_carry = wide[WIDTH];
            end
            OP_XOR: alu_res = a_ext ^ acc_q;
            OP_ROR: alu_res = WIDTH'((|bus.a) | (|acc_q));
            OP_SHL: alu_res = (32'(bus.a) >= WU) ? '0 : (acc_q << bus.a);
            OP_SHR: alu_res = (32'(bus.a) >= WU) ? '0 : (acc_q >> bus.a);
            default: alu_res = acc_q;
        endcase
    end

    // Accumulator/flag next values: clear first, then multiply completion, then single ops.
    always_comb begin
        acc_d   = acc_q;
        carry_d = carry_q;
        done_d  = 1'b0;
        if (bus.clear) begin
            acc_d   = '0;
            carry_d = 1'b0;
        end else if (mul_finish) begin
            acc_d   = product[WIDTH-1:0];
            carry_d = |product[P-1:WIDTH];
            done_d  = 1'b1;
        end else if (single_go) begin
            acc_d   = alu_res;
            carry_d = alu_carry;
            done_d  = 1'b1;
        end
    end

    // Accumulator, carry and done registers.
    always_ff @(posedge clock) begin
        if (reset) begin
            acc_q   <= '0;
            carry_q <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            acc_q   <= acc_d;
            carry_q <= carry_d;
            done_q  <= done_d;
        end
    end

    assign bus.acc   = acc_q;
    assign bus.carry = carry_q;
    assign bus.done  = done_q;
    assign bus.zero  = (acc_q == '0);

endmodule

// File: tb/tb_alu_accumulator.sv
// Self-checking bench: reset/handshake sequences, a vector table, and random ops vs a model.
module tb_alu_accumulator;
    import alu_pkg::*;

    localparam int W  = 8;
    localparam int AW = 4;

    logic clock;
    logic reset;
    int   tests;
    int   fails;
    logic [7:0] m_acc;
    logic       m_carry;

    alu_accumulator_if #(.WIDTH(W), .A_WIDTH(AW)) bus ();

    alu_accumulator #(.WIDTH(W), .A_WIDTH(AW)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    typedef struct {
        logic [2:0] op;
        logic [3:0] a;
        logic [7:0] init;
        logic [7:0] exp_acc;
        logic       exp_carry;
    } vec_t;

    vec_t vecs[16];

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Reference: {carry, acc} from plain integer arithmetic.
    function automatic logic [8:0] ref_fn(input logic [2:0] op, input logic [3:0] a, input logic [7:0] b);
        int ai, bi, r;
        logic c;
        ai = int'(a);
        bi = int'(b);
        r  = 0;
        c  = 1'b0;
        case (op)
            OP_INC: begin r = ai + 1;  c = (r > 255); end
            OP_ADD: begin r = ai + bi; c = (r > 255); end
            OP_SUB: begin r = bi - ai + 256; c = (ai > bi); end
            OP_XOR: r = ai ^ bi;
            OP_ROR: r = (ai != 0 || bi != 0) ? 1 : 0;
            OP_SHL: r = (ai >= 8) ? 0 : bi * (1 << ai);
            OP_SHR: r = (ai >= 8) ? 0 : bi / (1 << ai);
            default: begin r = ai * bi; c = (r > 255); end
        endcase
        return {c, 8'(r % 256)};
    endfunction

    // One full transaction, checked cycle by cycle against the model.
    task automatic do_op(input logic [2:0] op, input logic [3:0] a);
        logic [8:0] r;
        r = ref_fn(op, a, m_acc);
        bus.op = op;
        bus.a = a;
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        if (op == OP_MUL) begin
            for (int i = 0; i < AW; i++) begin
                check("mul_busy", 32'(bus.busy), 32'd1);
                check("mul_hold", 32'(bus.acc), 32'(m_acc));
                check("mul_nodone", 32'(bus.done), 32'd0);
                bus.start = 1'b1;
                bus.op = OP_INC;
                bus.a = 4'($urandom_range(0, 15));
                tick();
            end
            bus.start = 1'b0;
        end
        check("op_acc", 32'(bus.acc), 32'(r[7:0]));
        check("op_carry", 32'(bus.carry), 32'(r[8]));
        check("op_zero", 32'(bus.zero), 32'(r[7:0] == 8'h00));
        check("op_done", 32'(bus.done), 32'd1);
        check("op_busy", 32'(bus.busy), 32'd0);
        m_acc = r[7:0];
        m_carry = r[8];
        $display("[TB] op=%0d a=%0h -> acc=%02h carry=%0b", op, a, bus.acc, bus.carry);
    endtask

    task automatic do_clear();
        bus.clear = 1'b1;
        tick();
        bus.clear = 1'b0;
        check("clear_acc", 32'(bus.acc), 32'd0);
        check("clear_carry", 32'(bus.carry), 32'd0);
        m_acc = 8'h00;
        m_carry = 1'b0;
    endtask

    task automatic load_acc(input logic [7:0] v);
        logic [7:0] t;
        t = v;
        do_clear();
        if (t[7:4] != 4'h0) begin
            do_op(OP_ADD, t[7:4]);
            do_op(OP_SHL, 4'h4);
        end
        if (t[3:0] != 4'h0) do_op(OP_ADD, t[3:0]);
    endtask

    // Start a multiply from acc=3, a=5 and kill it on the 2nd busy cycle with clear or reset.
    task automatic abort_mul(input logic use_reset);
        int pulses;
        load_acc(8'h03);
        bus.op = OP_MUL;
        bus.a = 4'h5;
        bus.start = 1'b1;
        tick();
        check("abort_busy1", 32'(bus.busy), 32'd1);
        if (use_reset) reset = 1'b1;
        else bus.clear = 1'b1;
        tick();
        reset = 1'b0;
        bus.clear = 1'b0;
        check("abort_acc", 32'(bus.acc), 32'd0);
        check("abort_busy", 32'(bus.busy), 32'd0);
        check("abort_done", 32'(bus.done), 32'd0);
        bus.start = 1'b0;
        tick();
        check("abort_idle", 32'(bus.busy), 32'd0);
        pulses = 0;
        for (int i = 0; i < 6; i++) begin
            if (bus.done) pulses++;
            tick();
        end
        check("abort_no_done", 32'(pulses), 32'd0);
        check("abort_acc_after", 32'(bus.acc), 32'd0);
        $display("[TB] abort via %s -> acc=%02h busy=%0b", use_reset ? "reset" : "clear", bus.acc, bus.busy);
        m_acc = 8'h00;
        m_carry = 1'b0;
    endtask

    initial begin
        int cyc;
        tests = 0;
        fails = 0;
        m_acc = 8'h00;
        m_carry = 1'b0;

        vecs[0]  = '{OP_ADD, 4'h1, 8'hFF, 8'h00, 1'b1};
        vecs[1]  = '{OP_SUB, 4'h3, 8'h00, 8'hFD, 1'b1};
        vecs[2]  = '{OP_MUL, 4'hA, 8'h0C, 8'h78, 1'b0};
        vecs[3]  = '{OP_MUL, 4'hF, 8'hF0, 8'h10, 1'b1};
        vecs[4]  = '{OP_SHL, 4'h9, 8'h81, 8'h00, 1'b0};
        vecs[5]  = '{OP_SHR, 4'h3, 8'h80, 8'h10, 1'b0};
        vecs[6]  = '{OP_XOR, 4'hF, 8'h5A, 8'h55, 1'b0};
        vecs[7]  = '{OP_INC, 4'hF, 8'h33, 8'h10, 1'b0};
        vecs[8]  = '{OP_ROR, 4'h0, 8'h00, 8'h00, 1'b0};
        vecs[9]  = '{OP_ROR, 4'h0, 8'h40, 8'h01, 1'b0};
        vecs[10] = '{OP_ROR, 4'h1, 8'h00, 8'h01, 1'b0};
        vecs[11] = '{OP_ADD, 4'hF, 8'hF5, 8'h04, 1'b1};
        vecs[12] = '{OP_SUB, 4'h5, 8'h05, 8'h00, 1'b0};
        vecs[13] = '{OP_SHL, 4'h7, 8'h03, 8'h80, 1'b0};
        vecs[14] = '{OP_SHR, 4'h8, 8'hFF, 8'h00, 1'b0};
        vecs[15] = '{OP_MUL, 4'h0, 8'hFF, 8'h00, 1'b0};

        // Reset held two cycles with start asserted, then the start is taken.
        reset = 1'b1;
        bus.clear = 1'b0;
        bus.start = 1'b1;
        bus.op = OP_INC;
        bus.a = 4'h0;
        for (int i = 0; i < 2; i++) begin
            tick();
            check("rst_acc", 32'(bus.acc), 32'd0);
            check("rst_carry", 32'(bus.carry), 32'd0);
            check("rst_zero", 32'(bus.zero), 32'd1);
            check("rst_busy", 32'(bus.busy), 32'd0);
            check("rst_done", 32'(bus.done), 32'd0);
        end
        reset = 1'b0;
        tick();
        bus.start = 1'b0;
        check("post_rst_acc", 32'(bus.acc), 32'h01);
        check("post_rst_done", 32'(bus.done), 32'd1);
        $display("[TB] reset release inc -> acc=%02h", bus.acc);
        tick();
        check("done_one_cycle", 32'(bus.done), 32'd0);
        m_acc = 8'h01;

        // Vector table.
        foreach (vecs[i]) begin
            load_acc(vecs[i].init);
            bus.op = vecs[i].op;
            bus.a = vecs[i].a;
            bus.start = 1'b1;
            tick();
            cyc = 1;
            if (vecs[i].op == OP_MUL) begin
                bus.op = OP_INC;
                while (!bus.done && cyc < 12) begin
                    tick();
                    cyc++;
                end
                check("vec_mul_latency", 32'(cyc), 32'(AW + 1));
            end
            bus.start = 1'b0;
            check("vec_acc", 32'(bus.acc), 32'(vecs[i].exp_acc));
            check("vec_carry", 32'(bus.carry), 32'(vecs[i].exp_carry));
            check("vec_zero", 32'(bus.zero), 32'(vecs[i].exp_acc == 8'h00));
            check("vec_done", 32'(bus.done), 32'd1);
            $display("[TB] vec %0d op=%0d a=%0h init=%02h -> acc=%02h carry=%0b",
                     i, vecs[i].op, vecs[i].a, vecs[i].init, bus.acc, bus.carry);
            tick();
            check("vec_done_drop", 32'(bus.done), 32'd0);
            m_acc = vecs[i].exp_acc;
            m_carry = vecs[i].exp_carry;
        end

        abort_mul(1'b0);
        abort_mul(1'b1);

        // Back-to-back single-cycle ops.
        do_clear();
        bus.a = 4'h2;
        bus.start = 1'b1;
        bus.op = OP_INC;
        tick();
        check("b2b_acc0", 32'(bus.acc), 32'h03);
        check("b2b_done0", 32'(bus.done), 32'd1);
        bus.op = OP_ADD;
        tick();
        check("b2b_acc1", 32'(bus.acc), 32'h05);
        check("b2b_done1", 32'(bus.done), 32'd1);
        tick();
        check("b2b_acc2", 32'(bus.acc), 32'h07);
        check("b2b_done2", 32'(bus.done), 32'd1);
        bus.start = 1'b0;
        tick();
        check("b2b_done_end", 32'(bus.done), 32'd0);
        $display("[TB] back-to-back -> acc=%02h", bus.acc);
        m_acc = 8'h07;

        // Randomized ops against the model.
        for (int n = 0; n < 150; n++) begin
            if ($urandom_range(0, 15) == 0) do_clear();
            do_op(3'($urandom_range(0, 7)), 4'($urandom_range(0, 15)));
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
